// File: rtl/led_chaser_seq_if.sv
// Control and LED-drive bundle between the chaser sequencer and its driver.
// Handshake: there is no ready path. run/mode/step/blank are level inputs that
// are sampled on every rising clock edge. tick is the valid strobe: it is high
// for exactly the one cycle in which switch presents a new value. enable is an
// unqualified registered level. dir_dbg exposes the ping-pong direction state
// (0 = up, 1 = down) so that checkers can observe it.
interface led_chaser_seq_if;
    logic       run;
    logic [1:0] mode;
    logic       step;
    logic       blank;
    logic [2:0] switch;
    logic [2:0] enable;
    logic       tick;
    logic       dir_dbg;

    modport master (
        output run, mode, step, blank,
        input  switch, enable, tick, dir_dbg
    );

    modport slave (
        input  run, mode, step, blank,
        output switch, enable, tick, dir_dbg
    );
endinterface

// File: rtl/led_chaser_seq.sv
// Running-light / ping-pong sequencer feeding a registered 3-to-8 LED decoder.
// A prescaler paces the automatic steps while running. While paused, single-step
// requests advance the light instead. Blanking only changes the decoder enable
// code; stepping continues underneath it.
module led_chaser_seq #(
    parameter int DIV = 4
) (
    input logic            clk,
    input logic            rst,
    led_chaser_seq_if.slave bus
);
    localparam int         CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [2:0] EN_ON   = 3'd4;
    localparam logic [2:0] EN_OFF  = 3'd0;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    switch_q, switch_d;
    logic [2:0]    enable_q, enable_d;
    logic          tick_q, tick_d;
    dir_e          dir_q, dir_d;
    logic          adv;
    mode_e         mode;

    assign mode = mode_e'(bus.mode);

    // Next-state: prescaler, advance decision, LED index / direction, enable code.
    always_comb begin
        cnt_d    = cnt_q;
        adv      = 1'b0;
        switch_d = switch_q;
        dir_d    = dir_q;
        tick_d   = 1'b0;
        enable_d = bus.blank ? EN_OFF : EN_ON;

        // A paused prescaler keeps its count, so resuming does not cause an extra step.
        if (bus.run) begin
            adv   = (cnt_q == CNT_MAX);
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end else begin
            adv = bus.step;
        end

        if (adv) begin
            case (mode)
                MODE_UP: begin
                    switch_d = switch_q + 3'd1;
                    tick_d   = 1'b1;
                end
                MODE_DOWN: begin
                    switch_d = switch_q - 3'd1;
                    tick_d   = 1'b1;
                end
                MODE_PING: begin
                    tick_d = 1'b1;
                    // The end LEDs are shown for one step only: bounce immediately.
                    if (dir_q == DIR_UP) begin
                        if (switch_q == 3'd7) begin
                            switch_d = 3'd6;
                            dir_d    = DIR_DOWN;
                        end else begin
                            switch_d = switch_q + 3'd1;
                        end
                    end else begin
                        if (switch_q == 3'd0) begin
                            switch_d = 3'd1;
                            dir_d    = DIR_UP;
                        end else begin
                            switch_d = switch_q - 3'd1;
                        end
                    end
                end
                default: begin
                    switch_d = switch_q;
                    tick_d   = 1'b0;
                end
            endcase
        end
    end

    // Single state register: prescaler, direction FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            switch_q <= 3'd0;
            enable_q <= EN_ON;
            tick_q   <= 1'b0;
            dir_q    <= DIR_UP;
        end else begin
            cnt_q    <= cnt_d;
            switch_q <= switch_d;
            enable_q <= enable_d;
            tick_q   <= tick_d;
            dir_q    <= dir_d;
        end
    end

    assign bus.switch  = switch_q;
    assign bus.enable  = enable_q;
    assign bus.tick    = tick_q;
    assign bus.dir_dbg = dir_q;
endmodule

// File: tb/tb_led_chaser_seq.sv
// Bench for led_chaser_seq: directed scenarios followed by randomized control
// traffic. A behavioural model predicts every clock edge, and a monitor compares
// the predictions with the DUT outputs.
module tb_led_chaser_seq;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;

    led_chaser_seq_if bus ();

    led_chaser_seq #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-edge outputs, packed as {dir_down, tick, enable[2:0], switch[2:0]}.
    logic [7:0] exp_q[$];

    // Reference model state: position 0..7 and direction +1 / -1.
    int m_sw, m_dir, m_cnt, m_tick, m_en;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sw   = 0;
        m_dir  = 1;
        m_cnt  = 0;
        m_tick = 0;
        m_en   = 4;
    endtask

    // One rising edge of the reference, using the chaser rules directly.
    task automatic model_edge(input int run, input int mode, input int stp, input int blank);
        int adv;
        if (run != 0) begin
            adv   = (m_cnt == DIV - 1) ? 1 : 0;
            m_cnt = (m_cnt + 1) % DIV;
        end else begin
            adv = stp;
        end
        m_tick = (adv != 0 && mode != 3) ? 1 : 0;
        if (adv != 0) begin
            case (mode)
                0: m_sw = (m_sw + 1) % 8;
                1: m_sw = (m_sw + 7) % 8;
                2: begin
                    // Reflect off the ends of the row.
                    if (m_sw + m_dir > 7 || m_sw + m_dir < 0) m_dir = -m_dir;
                    m_sw = m_sw + m_dir;
                end
                default: ;
            endcase
        end
        m_en = (blank != 0) ? 0 : 4;
    endtask

    function automatic logic [7:0] pack_exp();
        logic [7:0] e;
        e[2:0] = 3'(m_sw);
        e[5:3] = 3'(m_en);
        e[6]   = (m_tick != 0);
        e[7]   = (m_dir < 0);
        return e;
    endfunction

    // Driver: apply inputs for the coming edge, predict it, queue the prediction.
    task automatic cyc(input logic r, input logic [1:0] md, input logic s, input logic b);
        bus.run   = r;
        bus.mode  = md;
        bus.step  = s;
        bus.blank = b;
        if (!rst) model_reset();
        else      model_edge(int'(r), int'(md), int'(s), int'(b));
        exp_q.push_back(pack_exp());
        @(negedge clk);
    endtask

    // Monitor: after every rising edge, pop one prediction and compare it.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("switch", int'(bus.switch), int'(e[2:0]));
            check("enable", int'(bus.enable), int'(e[5:3]));
            check("tick",   int'(bus.tick),   int'(e[6]));
            check("dir",    int'(bus.dir_dbg), int'(e[7]));
        end
    end

    initial begin
        int guard;
        rst       = 1'b0;
        bus.run   = 1'b0;
        bus.mode  = 2'b00;
        bus.step  = 1'b0;
        bus.blank = 1'b0;
        model_reset();

        // Reset held with random inputs.
        repeat (6) cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rst = 1'b1;

        // Up mode: nine steps, through the 7->0 wrap.
        repeat (DIV * 9) cyc(1'b1, 2'b00, 1'b0, 1'b0);

        // Ping-pong from switch 0: a full bounce and two steps more.
        guard = 0;
        while (m_sw != 0 && guard < 100) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0);
            guard++;
        end
        check("reach_sw0", m_sw, 0);
        repeat (DIV * 16) cyc(1'b1, 2'b10, 1'b0, 1'b0);

        // Pause at 3 in down mode, then single steps; a step while running is ignored.
        guard = 0;
        while (m_sw != 3 && guard < 100) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0);
            guard++;
        end
        check("reach_sw3", m_sw, 3);
        repeat (20) cyc(1'b0, 2'b01, 1'b0, 1'b0);
        cyc(1'b0, 2'b01, 1'b1, 1'b0);
        cyc(1'b0, 2'b01, 1'b0, 1'b0);
        repeat (DIV * 2) cyc(1'b1, 2'b01, 1'b1, 1'b0);

        // Blank for three cycles while stepping continues.
        repeat (3) cyc(1'b1, 2'b00, 1'b0, 1'b1);
        repeat (4) cyc(1'b1, 2'b00, 1'b0, 1'b0);

        // Asynchronous reset mid-prescale at switch 5 while moving down.
        guard = 0;
        while (!(m_sw == 5 && m_dir < 0) && guard < 200) begin
            cyc(1'b1, 2'b10, 1'b0, 1'b0);
            guard++;
        end
        check("reach_sw5_down", m_sw, 5);
        cyc(1'b1, 2'b10, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("async_rst_switch", int'(bus.switch), 0);
        check("async_rst_dir",    int'(bus.dir_dbg), 0);
        check("async_rst_tick",   int'(bus.tick), 0);
        model_reset();
        cyc(1'b1, 2'b10, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (DIV * 3) cyc(1'b1, 2'b10, 1'b0, 1'b0);

        // Randomized control traffic with occasional resets.
        repeat (500) begin
            rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
        end
        rst = 1'b1;
        repeat (4) cyc(1'b1, 2'b00, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
